spi_cmd_regs: RTL and testbench

Command decoder and register bank sitting directly downstream of the SPI slave byte engine (SPI2). It consumes received bytes (SPI2 data_in/tx_send), interprets the first byte of each chip-select frame as a command, then writes or reads consecutive registers with address auto-increment. It supplies the next byte to transmit back to SPI2 data_out and exposes the register contents to the rest of the FPGA.

---
 rtl/spi_cmd_regs.sv | 189 ++++++++++++++++++
 tb/tb_spi_cmd_regs.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_regs.sv
// ---------------------------------------------------------------------------
// spi_cmd_regs
//
// Command decoder and 8-bit register bank behind the SPI slave byte engine.
// The first byte of each chip-select frame is a command:
//   bit7 = 1 write / 0 read, bits ADDR_W-1:0 = start address.
// Following bytes write (or read) consecutive registers with address
// auto-increment. The address wraps from NREGS-1 to 0.
// Register 0 is read-only and always reads ID_VALUE.
//
// Ports:
//   clk        system clock (shared with the SPI byte engine)
//   rst_n      asynchronous active-low reset
//   cs_n       SPI chip select from the pad, active-low, asynchronous
//   rx_data    received byte, stable while rx_valid is high
//   rx_valid   byte-complete flag, may stay high for several cycles
//   tx_data    next byte to shift out
//   regs_flat  register contents, reg k at [8k+7:8k]; reg 0 = ID_VALUE
//   wr_strobe  one-cycle pulse per accepted register write
//   wr_addr    address of the write flagged by wr_strobe
//   busy       high while a frame is active
// ---------------------------------------------------------------------------
module spi_cmd_regs #(
  parameter int          ADDR_W   = 4,
  parameter logic [7:0]  ID_VALUE = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cs_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic [7:0]                  tx_data,
  output logic [8*(2**ADDR_W)-1:0]    regs_flat,
  output logic                        wr_strobe,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic                        busy
);

  localparam int NREGS = 2**ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR,
    ST_RD
  } state_t;

  // -------------------------------------------------------------------------
  // Chip-select synchronizer and edge detection.
  // The synchronizer and its history flop reset to the "active" value so that
  // a reset taken while cs_n is still low never looks like a new frame start;
  // a fresh frame requires cs_n to go high and then low again.
  // -------------------------------------------------------------------------
  logic cs_s1_q, cs_s2_q, cs_act_prev_q;
  logic cs_act, cs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1_q       <= 1'b0;
      cs_s2_q       <= 1'b0;
      cs_act_prev_q <= 1'b1;
    end else begin
      cs_s1_q       <= cs_n;
      cs_s2_q       <= cs_s1_q;
      cs_act_prev_q <= cs_act;
    end
  end

  assign cs_act  = ~cs_s2_q;
  assign cs_rise = cs_act & ~cs_act_prev_q;

  // -------------------------------------------------------------------------
  // Byte event: rising edge of rx_valid, only counted inside an active frame.
  // Gating with cs_act makes a deassertion in the same cycle win.
  // -------------------------------------------------------------------------
  logic rx_valid_prev_q;
  logic byte_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_valid_prev_q <= 1'b0;
    else        rx_valid_prev_q <= rx_valid;
  end

  assign byte_ev = rx_valid & ~rx_valid_prev_q & cs_act;

  // -------------------------------------------------------------------------
  // Register bank and read view (index 0 is the constant ID).
  // -------------------------------------------------------------------------
  logic [7:0]        rd_view [NREGS];
  logic              wr_en;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] ptr_inc;

  assign rd_view[0]      = ID_VALUE;
  assign regs_flat[7:0]  = ID_VALUE;

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [7:0] reg_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  reg_q <= 8'h00;
        else if (wr_en && (ptr_q == ADDR_W'(gi)))    reg_q <= rx_data;
      end
      assign rd_view[gi]           = reg_q;
      assign regs_flat[8*gi +: 8]  = reg_q;
    end
  endgenerate

  // Reserved command bits carry no meaning.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^rx_data[6:ADDR_W];

  // -------------------------------------------------------------------------
  // Frame FSM
  // -------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [7:0]        tx_q, tx_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  assign ptr_inc = ptr_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      tx_q        <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tx_d        = tx_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_en       = 1'b0;

    if (state_q == ST_IDLE) begin
      if (cs_rise) begin
        state_d = ST_CMD;
        tx_d    = 8'h00;
      end
    end else if (!cs_act) begin
      // Frame ended: drop anything in progress.
      state_d = ST_IDLE;
    end else if (byte_ev) begin
      case (state_q)
        ST_CMD: begin
          ptr_d = rx_data[ADDR_W-1:0];
          if (rx_data[7]) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
            tx_d    = rd_view[rx_data[ADDR_W-1:0]];
          end
        end
        ST_WR: begin
          // Register 0 is read-only: silently discarded, no strobe.
          if (ptr_q != '0) begin
            wr_en       = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = ptr_q;
          end
          ptr_d = ptr_inc;
        end
        ST_RD: begin
          ptr_d = ptr_inc;
          tx_d  = rd_view[ptr_inc];
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign tx_data   = tx_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_cmd_regs.sv
module tb_spi_cmd_regs;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cs_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic [127:0] regs_flat;
  logic         wr_strobe;
  logic [3:0]   wr_addr;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Strobe log, written only by the monitor process.
  int         strobe_cnt = 0;
  logic [3:0] strobe_log [64];

  spi_cmd_regs #(.ADDR_W(4), .ID_VALUE(8'hA5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_log[strobe_cnt % 64] = wr_addr;
      strobe_cnt = strobe_cnt + 1;
    end
  end

  function automatic logic [7:0] reg_at(input int k);
    return regs_flat[8*k +: 8];
  endfunction

  task automatic frame_start();
    @(negedge clk); cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk); cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 1; k < 16; k++) begin
      checks++;
      if (reg_at(k) !== 8'h00) begin
        errors++; $display("FAIL reset_reg%0d got %h exp 00", k, reg_at(k));
      end
    end
    checks++;
    if (reg_at(0) !== 8'hA5) begin errors++; $display("FAIL reset_id got %h exp a5", reg_at(0)); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx got %h exp 00", tx_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", wr_strobe); end
    $display("test_reset done");
  endtask

  task automatic test_burst_write();
    int s0;
    s0 = strobe_cnt;
    frame_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bw_busy_on got %b exp 1", busy); end
    send_byte(8'h83, 1);
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    frame_end();
    checks++;
    if (reg_at(3) !== 8'h11) begin errors++; $display("FAIL bw_reg3 got %h exp 11", reg_at(3)); end
    checks++;
    if (reg_at(4) !== 8'h22) begin errors++; $display("FAIL bw_reg4 got %h exp 22", reg_at(4)); end
    checks++;
    if (strobe_cnt - s0 !== 2) begin errors++; $display("FAIL bw_strobes got %0d exp 2", strobe_cnt - s0); end
    checks++;
    if (strobe_log[s0 % 64] !== 4'd3) begin errors++; $display("FAIL bw_addr0 got %0d exp 3", strobe_log[s0 % 64]); end
    checks++;
    if (strobe_log[(s0 + 1) % 64] !== 4'd4) begin errors++; $display("FAIL bw_addr1 got %0d exp 4", strobe_log[(s0 + 1) % 64]); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bw_busy_off got %b exp 0", busy); end
    $display("test_burst_write done");
  endtask

  task automatic test_burst_read();
    int s0;
    s0 = strobe_cnt;
    frame_start();
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL br_tx_start got %h exp 00", tx_data); end
    send_byte(8'h03, 1);
    checks++;
    if (tx_data !== 8'h11) begin errors++; $display("FAIL br_tx_cmd got %h exp 11", tx_data); end
    send_byte(8'hFF, 1);
    checks++;
    if (tx_data !== 8'h22) begin errors++; $display("FAIL br_tx_b2 got %h exp 22", tx_data); end
    send_byte(8'hFF, 1);
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL br_tx_b3 got %h exp 00", tx_data); end
    frame_end();
    checks++;
    if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL br_strobes got %0d exp 0", strobe_cnt - s0); end
    $display("test_burst_read done");
  endtask

  task automatic test_wrap();
    int s0;
    s0 = strobe_cnt;
    frame_start();
    send_byte(8'h8F, 1);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    frame_end();
    checks++;
    if (reg_at(15) !== 8'hAA) begin errors++; $display("FAIL wrap_reg15 got %h exp aa", reg_at(15)); end
    checks++;
    if (reg_at(0) !== 8'hA5) begin errors++; $display("FAIL wrap_id got %h exp a5", reg_at(0)); end
    checks++;
    if (reg_at(1) !== 8'h00) begin errors++; $display("FAIL wrap_reg1 got %h exp 00", reg_at(1)); end
    checks++;
    if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL wrap_strobes got %0d exp 1", strobe_cnt - s0); end
    checks++;
    if (strobe_log[s0 % 64] !== 4'd15) begin errors++; $display("FAIL wrap_addr got %0d exp 15", strobe_log[s0 % 64]); end
    frame_start();
    send_byte(8'h0F, 1);
    checks++;
    if (tx_data !== 8'hAA) begin errors++; $display("FAIL wrap_rd15 got %h exp aa", tx_data); end
    send_byte(8'h00, 1);
    checks++;
    if (tx_data !== 8'hA5) begin errors++; $display("FAIL wrap_rd0 got %h exp a5", tx_data); end
    frame_end();
    $display("test_wrap done");
  endtask

  task automatic test_long_valid();
    int s0;
    s0 = strobe_cnt;
    frame_start();
    send_byte(8'h82, 1);
    send_byte(8'h55, 10);
    frame_end();
    checks++;
    if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL long_strobes got %0d exp 1", strobe_cnt - s0); end
    checks++;
    if (strobe_log[s0 % 64] !== 4'd2) begin errors++; $display("FAIL long_addr got %0d exp 2", strobe_log[s0 % 64]); end
    checks++;
    if (reg_at(2) !== 8'h55) begin errors++; $display("FAIL long_reg2 got %h exp 55", reg_at(2)); end
    checks++;
    if (reg_at(3) !== 8'h11) begin errors++; $display("FAIL long_reg3 got %h exp 11", reg_at(3)); end
    $display("test_long_valid done");
  endtask

  task automatic test_abort();
    int s0;
    s0 = strobe_cnt;
    // cs_n deasserted so that the synchronized fall lands in the same cycle
    // as the rx_valid edge of the next data byte.
    frame_start();
    send_byte(8'h86, 1);
    send_byte(8'h77, 1);
    @(negedge clk); cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rx_data = 8'h99; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (reg_at(6) !== 8'h77) begin errors++; $display("FAIL abort_reg6 got %h exp 77", reg_at(6)); end
    checks++;
    if (reg_at(7) !== 8'h00) begin errors++; $display("FAIL abort_reg7 got %h exp 00", reg_at(7)); end
    checks++;
    if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL abort_strobes got %0d exp 1", strobe_cnt - s0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end

    // Reset pulse in the middle of a write burst.
    frame_start();
    send_byte(8'h88, 1);
    send_byte(8'h12, 1);
    checks++;
    if (reg_at(8) !== 8'h12) begin errors++; $display("FAIL rst_pre_reg8 got %h exp 12", reg_at(8)); end
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (reg_at(8) !== 8'h00) begin errors++; $display("FAIL rst_reg8 got %h exp 00", reg_at(8)); end
    checks++;
    if (reg_at(3) !== 8'h00) begin errors++; $display("FAIL rst_reg3 got %h exp 00", reg_at(3)); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    // cs_n is still low: bytes must be ignored.
    s0 = strobe_cnt;
    send_byte(8'h89, 1);
    send_byte(8'h34, 1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy got %b exp 0", busy); end
    checks++;
    if (reg_at(9) !== 8'h00) begin errors++; $display("FAIL rst_hold_reg9 got %h exp 00", reg_at(9)); end
    checks++;
    if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL rst_hold_strobes got %0d exp 0", strobe_cnt - s0); end
    frame_end();
    // New frame after a fresh cs_n falling edge.
    frame_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_new_busy got %b exp 1", busy); end
    send_byte(8'h89, 1);
    send_byte(8'h34, 1);
    frame_end();
    checks++;
    if (reg_at(9) !== 8'h34) begin errors++; $display("FAIL rst_new_reg9 got %h exp 34", reg_at(9)); end
    $display("test_abort done");
  endtask

  initial begin
    test_reset();
    test_burst_write();
    test_burst_read();
    test_wrap();
    test_long_valid();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
